led_fader: RTL and testbench



---
 rtl/led_fader_pkg.sv | 16 +
 rtl/led_fader_channel.sv | 76 +++++++
 rtl/led_fader.sv | 92 +++++++++
 tb/tb_led_fader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/led_fader_pkg.sv
// led_fader_pkg: shared constants and types for the LED fader.
//   LEVEL_W      - width of a brightness level
//   LEVEL_MAX    - full-on level (also one more than the last PWM count)
//   chan_state_t - per-channel fade direction, derived from level vs target
package led_fader_pkg;

  localparam int LEVEL_W   = 8;
  localparam int LEVEL_MAX = 255;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RISE = 2'd1,
    FALL = 2'd2
  } chan_state_t;

endpackage

// File: rtl/led_fader_channel.sv
// led_fader_channel: one fading LED channel.
// Ports:
//   clk_clk       - system clock
//   reset_reset_n - synchronous active-low reset
//   target        - 1 = fade toward full-on, 0 = fade toward off
//   step_tick     - one-cycle pulse that allows a single level step
//   bypass        - 1 = snap level to target every cycle
//   pwm_cnt       - shared free-running PWM counter
//   level         - current brightness level
//   pwm_on        - PWM compare result for this channel
//   busy_i        - level after this cycle's update still differs from target
module led_fader_channel
  import led_fader_pkg::*;
#(
  parameter int FULL_LEVEL = LEVEL_MAX
) (
  input  logic               clk_clk,
  input  logic               reset_reset_n,
  input  logic               target,
  input  logic               step_tick,
  input  logic               bypass,
  input  logic [LEVEL_W-1:0] pwm_cnt,
  output logic [LEVEL_W-1:0] level,
  output logic               pwm_on,
  output logic               busy_i
);

  localparam logic [LEVEL_W-1:0] ONE_LEVEL = LEVEL_W'(1);

  logic [LEVEL_W-1:0] level_reg;
  logic [LEVEL_W-1:0] level_next;
  logic [LEVEL_W-1:0] target_level;
  chan_state_t        state;

  assign target_level = target ? LEVEL_W'(FULL_LEVEL) : '0;

  // Direction is purely a function of where the level sits relative to the
  // target, so a target change mid-fade just flips direction from the
  // current value; steps only ever head toward the target, so no wrap.
  always_comb begin
    state = IDLE;
    if (level_reg < target_level) begin
      state = RISE;
    end else if (level_reg > target_level) begin
      state = FALL;
    end
  end

  always_comb begin
    level_next = level_reg;
    if (bypass) begin
      level_next = target_level;
    end else if (step_tick) begin
      case (state)
        RISE:    level_next = level_reg + ONE_LEVEL;
        FALL:    level_next = level_reg - ONE_LEVEL;
        default: level_next = level_reg;
      endcase
    end
  end

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      level_reg <= '0;
    end else begin
      level_reg <= level_next;
    end
  end

  assign level  = level_reg;
  // pwm_cnt never reaches FULL_LEVEL, so full level is solid on, zero solid off.
  assign pwm_on = (pwm_cnt < level_reg);
  // Uses the post-update level so busy drops on the same edge as the final step.
  assign busy_i = (level_next != target_level);

endmodule

// File: rtl/led_fader.sv
// led_fader: fades the LED PIO outputs into the board LED pins.
// Ports:
//   clk_clk       - system clock (same clock as the PIO)
//   reset_reset_n - synchronous active-low reset
//   leds_in       - PIO LED bits; each selects full-on or off as the target
//   bypass        - 1 = drive pins directly from the registered PIO bits
//   led_out       - registered LED pin drive
//   busy          - registered; 1 while any level differs from its target
module led_fader #(
  parameter int N_LEDS      = 8,
  parameter int LEVEL_MAX   = 255,
  parameter int STEP_CYCLES = 196608
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [N_LEDS-1:0] leds_in,
  input  logic              bypass,
  output logic [N_LEDS-1:0] led_out,
  output logic              busy
);

  import led_fader_pkg::*;

  localparam int STEP_W = (STEP_CYCLES > 2) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [STEP_W-1:0]  STEP_LAST = STEP_W'(STEP_CYCLES - 1);
  localparam logic [STEP_W-1:0]  STEP_ONE  = STEP_W'(1);
  localparam logic [LEVEL_W-1:0] PWM_LAST  = LEVEL_W'(LEVEL_MAX - 1);
  localparam logic [LEVEL_W-1:0] PWM_ONE   = LEVEL_W'(1);

  logic [N_LEDS-1:0]  in_q_reg;
  logic [LEVEL_W-1:0] pwm_cnt_reg;
  logic [STEP_W-1:0]  step_cnt_reg;
  logic [N_LEDS-1:0]  led_out_reg;
  logic               busy_reg;

  logic               step_tick;
  logic [N_LEDS-1:0]  pwm_on_vec;
  logic [N_LEDS-1:0]  busy_vec;
  logic [N_LEDS-1:0]  led_out_next;
  logic [LEVEL_W-1:0] level [N_LEDS];

  assign step_tick = (step_cnt_reg == STEP_LAST);

  // Counters run regardless of bypass so leaving bypass resumes on the
  // normal step/PWM cadence.
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      in_q_reg     <= '0;
      pwm_cnt_reg  <= '0;
      step_cnt_reg <= '0;
      led_out_reg  <= '0;
      busy_reg     <= 1'b0;
    end else begin
      in_q_reg     <= leds_in;
      pwm_cnt_reg  <= (pwm_cnt_reg == PWM_LAST) ? '0 : pwm_cnt_reg + PWM_ONE;
      step_cnt_reg <= step_tick ? '0 : step_cnt_reg + STEP_ONE;
      led_out_reg  <= led_out_next;
      busy_reg     <= |busy_vec;
    end
  end

  assign led_out_next = bypass ? in_q_reg : pwm_on_vec;

  generate
    for (genvar gi = 0; gi < N_LEDS; gi++) begin : g_chan
      led_fader_channel #(
        .FULL_LEVEL (LEVEL_MAX)
      ) u_chan (
        .clk_clk       (clk_clk),
        .reset_reset_n (reset_reset_n),
        .target        (in_q_reg[gi]),
        .step_tick     (step_tick),
        .bypass        (bypass),
        .pwm_cnt       (pwm_cnt_reg),
        .level         (level[gi]),
        .pwm_on        (pwm_on_vec[gi]),
        .busy_i        (busy_vec[gi])
      );

      // A dark channel must never produce a PWM pulse.
      always_ff @(posedge clk_clk) begin
        if (reset_reset_n) begin
          assert (!((level[gi] == '0) && pwm_on_vec[gi]));
        end
      end
    end
  endgenerate

  assign led_out = led_out_reg;
  assign busy    = busy_reg;

endmodule

// File: tb/tb_led_fader.sv
// tb_led_fader: directed self-checking bench for led_fader.
// A fast instance (4 clocks per step) covers reset, fades, reversal and
// bypass; a slow instance (300 clocks per step) holds a level long enough
// to measure one whole PWM period.
module tb_led_fader;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [7:0] leds_in;
  logic       bypass;
  logic [7:0] led_out;
  logic       busy;

  logic       rst_s_n;
  logic [7:0] leds_in_s;
  logic       bypass_s;
  logic [7:0] led_out_s;
  logic       busy_s;

  int vectors     = 0;
  int miscompares = 0;

  led_fader #(
    .N_LEDS      (8),
    .LEVEL_MAX   (255),
    .STEP_CYCLES (4)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .leds_in       (leds_in),
    .bypass        (bypass),
    .led_out       (led_out),
    .busy          (busy)
  );

  led_fader #(
    .N_LEDS      (8),
    .LEVEL_MAX   (255),
    .STEP_CYCLES (300)
  ) dut_s (
    .clk_clk       (clk),
    .reset_reset_n (rst_s_n),
    .leds_in       (leds_in_s),
    .bypass        (bypass_s),
    .led_out       (led_out_s),
    .busy          (busy_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) begin
      $display("vec %0s: got %0h expected %0h", tag, obs, exp);
    end else begin
      miscompares++;
      $error("FAIL %0s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Two reset edges; afterwards edge 1 is the first edge with reset released.
  task automatic do_reset(input logic [7:0] leds, input logic byp);
    rst_n   = 1'b0;
    leds_in = leds;
    bypass  = byp;
    tick(2);
    rst_n = 1'b1;
  endtask

  initial begin
    int bad;
    int highs;
    int waited;

    rst_n     = 1'b0;
    leds_in   = 8'hFF;
    bypass    = 1'b0;
    rst_s_n   = 1'b0;
    leds_in_s = 8'h01;
    bypass_s  = 1'b0;

    // 1. Reset held for 5 clocks with all PIO bits set
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("t1_rst_led_out", led_out, 8'h00);
      check("t1_rst_busy", busy, 1'b0);
    end
    rst_n   = 1'b1;
    rst_s_n = 1'b1;
    tick(1);
    check("t1_busy_edge1", busy, 1'b0);
    tick(1);
    check("t1_busy_edge2", busy, 1'b1);

    // 2. Full rise of channel 0: level k after edge 4k
    do_reset(8'h01, 1'b0);
    tick(400);
    check("t2_level_100", dut.level[0], 8'd100);
    tick(619);
    check("t2_level_254", dut.level[0], 8'd254);
    check("t2_busy_before_final", busy, 1'b1);
    tick(1);
    check("t2_level_255", dut.level[0], 8'd255);
    check("t2_busy_fall", busy, 1'b0);
    bad = 0;
    for (int i = 0; i < 300; i++) begin
      tick(1);
      if (led_out !== 8'h01) bad++;
    end
    check("t2_led_out_solid_cycles_wrong", bad, 0);
    check("t2_busy_idle", busy, 1'b0);

    // 3. PWM duty at a frozen level of 64 on the slow instance
    waited = 0;
    while (dut_s.level[0] !== 8'd63 && waited < 40000) begin
      tick(1);
      waited++;
    end
    while (dut_s.level[0] !== 8'd64 && waited < 40000) begin
      tick(1);
      waited++;
    end
    check("t3_reached_64", (waited < 40000) ? 1 : 0, 1);
    highs = 0;
    for (int i = 0; i < 255; i++) begin
      tick(1);
      highs += int'(led_out_s[0]);
    end
    check("t3_duty_highs", highs, 64);
    check("t3_level_held", dut_s.level[0], 8'd64);
    check("t3_other_leds", led_out_s[7:1], 7'h00);

    // 4. Reversal at level 100
    do_reset(8'h01, 1'b0);
    tick(400);
    check("t4_level_100", dut.level[0], 8'd100);
    leds_in = 8'h00;
    tick(3);
    check("t4_level_hold", dut.level[0], 8'd100);
    tick(1);
    check("t4_level_99", dut.level[0], 8'd99);
    tick(395);
    check("t4_level_1", dut.level[0], 8'd1);
    check("t4_busy_1", busy, 1'b1);
    tick(1);
    check("t4_level_0", dut.level[0], 8'd0);
    check("t4_busy_0", busy, 1'b0);
    tick(20);
    check("t4_no_wrap", dut.level[0], 8'd0);
    check("t4_busy_idle", busy, 1'b0);

    // 5. Bypass with A5, then release and fade down
    do_reset(8'hA5, 1'b1);
    tick(1);
    check("t5_led_out_edge1", led_out, 8'h00);
    tick(1);
    check("t5_led_out_edge2", led_out, 8'hA5);
    check("t5_busy_edge2", busy, 1'b0);
    check("t5_level0_snap", dut.level[0], 8'd255);
    check("t5_level1_snap", dut.level[1], 8'd0);
    tick(3);
    check("t5_led_out_edge5", led_out, 8'hA5);
    check("t5_busy_edge5", busy, 1'b0);
    bypass  = 1'b0;
    leds_in = 8'h00;
    tick(1);
    check("t5_no_glitch", led_out, 8'hA5);
    check("t5_busy_edge6", busy, 1'b0);
    check("t5_level0_edge6", dut.level[0], 8'd255);
    tick(1);
    check("t5_busy_edge7", busy, 1'b1);
    tick(1);
    check("t5_level0_254", dut.level[0], 8'd254);
    check("t5_level2_254", dut.level[2], 8'd254);
    check("t5_level5_254", dut.level[5], 8'd254);
    check("t5_level7_254", dut.level[7], 8'd254);
    check("t5_level1_0", dut.level[1], 8'd0);
    tick(4);
    check("t5_level0_253", dut.level[0], 8'd253);

    // 6. Reset asserted at level 150
    do_reset(8'h01, 1'b0);
    tick(600);
    check("t6_level_150", dut.level[0], 8'd150);
    rst_n = 1'b0;
    tick(1);
    check("t6_level_0", dut.level[0], 8'd0);
    check("t6_led_out", led_out, 8'h00);
    check("t6_busy", busy, 1'b0);
    check("t6_pwm_cnt", dut.pwm_cnt_reg, 8'd0);
    check("t6_step_cnt", dut.step_cnt_reg, 2'd0);
    check("t6_in_q", dut.in_q_reg, 8'h00);
    rst_n = 1'b1;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
